// File: rtl/pc_fetch_unit_pkg.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_pkg
// Shared definitions for the PC / instruction fetch unit:
//   - fetch_state_e      : fetch FSM state encoding (S_REQ, S_VALID, S_TRAP)
//   - RESET_PC_DEFAULT   : default PC loaded on reset
//   - NOP_INST_DEFAULT   : default instruction word shown while nothing is valid
//   - pc_plus4()         : sequential PC increment, wraps modulo 2^32
// ---------------------------------------------------------------------------
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,  // request outstanding, waiting for IMemAck
        S_VALID = 2'd1,  // Inst holds the instruction at PC
        S_TRAP  = 2'd2   // misaligned taken target; frozen until reset
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // Carry out of bit 31 is dropped on purpose: 0xFFFF_FFFC wraps to 0.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Holds the program counter, fetches the instruction at PC from instruction
// memory and presents it to the core until the core retires it.
//
// Ports:
//   clk          in   clock, all state on rising edge
//   rst          in   synchronous active-high reset
//   NextPCSrc    in   1 = take ALURes target, 0 = sequential PC+4
//   ALURes       in   branch/jump target (bit 0 is forced to 0)
//   Retire       in   core finished the current instruction
//   Stall        in   core hold, blocks Retire
//   IMemReq      out  instruction memory read request
//   IMemAddr     out  instruction memory address (= PC)
//   IMemAck      in   read data returned this cycle
//   IMemRData    in   read data
//   PC           out  current instruction address
//   PCPlus4      out  PC + 4 (combinational)
//   Inst         out  registered instruction, NOP_INST while not valid
//   InstValid    out  Inst holds the instruction at PC
//   Misaligned   out  sticky misaligned-target trap flag
//   dbg_state_o  out  current fetch FSM state
//
// Memory handshake: IMemReq is the request-valid and IMemAck the response.
// Once IMemReq rises it stays high with IMemAddr stable until the cycle in
// which IMemAck is seen; that cycle completes the transfer and IMemReq drops
// on the next cycle. IMemAck in any other cycle carries no transfer.
// ---------------------------------------------------------------------------
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         NextPCSrc,
    input  logic [31:0]  ALURes,
    input  logic         Retire,
    input  logic         Stall,
    output logic         IMemReq,
    output logic [31:0]  IMemAddr,
    input  logic         IMemAck,
    input  logic [31:0]  IMemRData,
    output logic [31:0]  PC,
    output logic [31:0]  PCPlus4,
    output logic [31:0]  Inst,
    output logic         InstValid,
    output logic         Misaligned,
    output fetch_state_e dbg_state_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  inst_q, inst_d;

    logic [31:0]  seq_pc;
    logic [31:0]  target_pc;
    logic [31:0]  next_pc;
    logic         retire_ok;

    assign seq_pc    = pc_plus4(pc_q);
    // Jump targets are halfword aligned by clearing bit 0.
    assign target_pc = ALURes & ~32'h0000_0001;
    assign next_pc   = NextPCSrc ? target_pc : seq_pc;
    assign retire_ok = Retire && !Stall;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        IMemReq   = 1'b0;
        InstValid = 1'b0;
        Misaligned = 1'b0;

        case (state_q)
            S_REQ: begin
                IMemReq = 1'b1;
                if (IMemAck) begin
                    inst_d  = IMemRData;
                    state_d = S_VALID;
                end
            end

            S_VALID: begin
                InstValid = 1'b1;
                if (retire_ok) begin
                    // Inst register returns to NOP whenever it stops being
                    // valid, so Inst can be driven straight from it.
                    inst_d = NOP_INST;
                    if (NextPCSrc && next_pc[1]) begin
                        // Misaligned taken target: PC keeps the faulting
                        // instruction's address for the trap handler.
                        state_d = S_TRAP;
                    end else begin
                        pc_d    = next_pc;
                        state_d = S_REQ;
                    end
                end
            end

            S_TRAP: begin
                Misaligned = 1'b1;
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign IMemAddr    = pc_q;
    assign PC          = pc_q;
    assign PCPlus4     = seq_pc;
    assign Inst        = inst_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
    import pc_fetch_unit_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1;
    logic         NextPCSrc = 1'b0;
    logic [31:0]  ALURes = '0;
    logic         Retire = 1'b0;
    logic         Stall = 1'b0;
    logic         IMemReq;
    logic [31:0]  IMemAddr;
    logic         IMemAck = 1'b0;
    logic [31:0]  IMemRData = '0;
    logic [31:0]  PC;
    logic [31:0]  PCPlus4;
    logic [31:0]  Inst;
    logic         InstValid;
    logic         Misaligned;
    fetch_state_e dbg_state;

    pc_fetch_unit dut (
        .clk        (clk),
        .rst        (rst),
        .NextPCSrc  (NextPCSrc),
        .ALURes     (ALURes),
        .Retire     (Retire),
        .Stall      (Stall),
        .IMemReq    (IMemReq),
        .IMemAddr   (IMemAddr),
        .IMemAck    (IMemAck),
        .IMemRData  (IMemRData),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .Inst       (Inst),
        .InstValid  (InstValid),
        .Misaligned (Misaligned),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural view of the unit: where the PC is, whether an instruction
    // is being presented, whether we are trapped, and which word is shown.
    logic [31:0] m_pc;
    bit          m_valid;
    bit          m_trap;
    logic [31:0] m_inst;
    bit          m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("imem_req",   {31'd0, IMemReq},   {31'd0, (!m_valid && !m_trap)});
        check_eq("imem_addr",  IMemAddr,           m_pc);
        check_eq("pc",         PC,                 m_pc);
        check_eq("pc_plus4",   PCPlus4,            m_pc + 32'd4);
        check_eq("inst",       Inst,               m_inst);
        check_eq("inst_valid", {31'd0, InstValid}, {31'd0, m_valid});
        check_eq("misaligned", {31'd0, Misaligned}, {31'd0, m_trap});
        check_eq("trap_state", {31'd0, (dbg_state == S_TRAP)}, {31'd0, m_trap});
    endtask

    task automatic model_update(input bit r, input bit src, input logic [31:0] alu,
                                input bit ret, input bit stl, input bit ack,
                                input logic [31:0] rdata);
        logic [31:0] tgt;
        if (r) begin
            m_pc = RPC; m_valid = 0; m_trap = 0; m_inst = NOP;
        end else if (m_trap) begin
            // frozen until reset
        end else if (!m_valid) begin
            if (ack) begin
                m_valid = 1; m_inst = rdata;
            end
        end else if (ret && !stl) begin
            m_valid = 0;
            m_inst  = NOP;
            tgt = {alu[31:1], 1'b0};
            if (src && tgt[1]) m_trap = 1;
            else if (src)      m_pc = tgt;
            else               m_pc = m_pc + 32'd4;
        end
    endtask

    // ---------------- driver ----------------
    // One cycle: check state left by the previous edge, then present new inputs.
    task automatic step(input bit r, input bit src, input logic [31:0] alu,
                        input bit ret, input bit stl, input bit ack,
                        input logic [31:0] rdata);
        @(negedge clk);
        if (m_known) check_outputs();
        rst = r; NextPCSrc = src; ALURes = alu; Retire = ret; Stall = stl;
        IMemAck = ack; IMemRData = rdata;
        model_update(r, src, alu, ret, stl, ack, rdata);
        if (r) m_known = 1'b1;
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 0, 0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset, then ack on the very first request cycle
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 0, 1, 32'h00A0_0093);
        check_eq("first_req_addr", IMemAddr, RPC);
        check_eq("first_req", {31'd0, IMemReq}, 32'd1);
        idle();
        check_eq("first_inst", Inst, 32'h00A0_0093);
        check_eq("first_valid", {31'd0, InstValid}, 32'd1);
        check_eq("first_pc", PC, 32'h0);

        // Jump to 0x100, fetch it
        step(0, 1, 32'h0000_0100, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h1111_1111);
        idle();
        check_eq("at_100", PC, 32'h100);

        // Sequential retire, late ack: address held while waiting
        step(0, 0, 32'hFFFF_FFFF, 1, 0, 0, 0);
        idle();
        check_eq("seq_pc", PC, 32'h104);
        check_eq("seq_valid", {31'd0, InstValid}, 32'd0);
        idle();
        idle();
        step(0, 0, 0, 0, 0, 1, 32'h2222_2222);
        check_eq("held_addr", IMemAddr, 32'h104);
        idle();

        // Stall with retire for 4 cycles, then release
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1, 1, 32'h5555_5555);
        check_eq("stall_pc", PC, 32'h104);
        check_eq("stall_inst", Inst, 32'h2222_2222);
        step(0, 1, 32'h0000_0201, 1, 0, 0, 0);
        idle();
        check_eq("target_pc", PC, 32'h200);

        // Wrap: go to 0xFFFFFFFC, retire sequentially
        step(0, 0, 0, 0, 0, 1, 32'h3333_3333);
        step(0, 1, 32'hFFFF_FFFD, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 32'h4444_4444);
        check_eq("top_pc", PC, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 0, 0, 0);
        idle();
        check_eq("wrap_pc", PC, 32'h0);

        // Misaligned taken target traps and freezes
        step(0, 0, 0, 0, 0, 1, 32'h6666_6666);
        step(0, 1, 32'h0000_0302, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 32'h0000_0400, 1, 0, 1, 32'h7777_7777);
        check_eq("trap_flag", {31'd0, Misaligned}, 32'd1);
        check_eq("trap_pc", PC, 32'h0);
        check_eq("trap_req", {31'd0, IMemReq}, 32'd0);

        // Reset with simultaneous ack while requesting
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 32'h8888_8888);
        idle();
        check_eq("rst_ack_inst", Inst, NOP);
        check_eq("rst_ack_pc", PC, RPC);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [31:0] alu;
            alu = $urandom;
            if ($urandom_range(0, 7) != 0) alu[1] = 1'b0;
            step($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)), alu,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1, $urandom);
        end
        @(negedge clk);
        check_outputs();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
